// File: rtl/mult_shift_add_seq_if.sv
// Operand, adder and result bundle for the sequential shift-add multiplier.
// The controller owns the slave side; the surrounding datapath owns master.
interface mult_shift_add_seq_if #(
    parameter int N = 8
);
    logic           start;
    logic [N-1:0]   dataa_in;
    logic [N-1:0]   datab_in;
    logic [2*N-1:0] add_a;
    logic [2*N-1:0] add_b;
    logic [2*N-1:0] add_sum;
    logic [2*N-1:0] product;
    logic           busy;
    logic           done;

    modport master (
        output start, dataa_in, datab_in, add_sum,
        input  add_a, add_b, product, busy, done
    );

    modport slave (
        input  start, dataa_in, datab_in, add_sum,
        output add_a, add_b, product, busy, done
    );
endinterface

// File: rtl/mult_shift_add_seq.sv
// Shift-add controller and accumulator for the N x N sequential multiplier.
// Feeds the shared 2N-bit adder and folds its sum back into the accumulator.
module mult_shift_add_seq #(
    parameter int N = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    mult_shift_add_seq_if.slave   bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] product_q, product_d;
    logic           done_q, done_d;

    logic [2*N-1:0] a_ext;
    logic [2*N-1:0] part;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    // Partial product for the current multiplier bit; zero outside RUN.
    always_comb begin
        a_ext = {{N{1'b0}}, a_q};
        part  = a_ext << cnt_q;
        if (state_q == RUN && b_q[cnt_q])
            bus.add_b = part;
        else
            bus.add_b = '0;
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.dataa_in;
                    b_d     = bus.datab_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = bus.add_sum;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    product_d = bus.add_sum;
                    done_d    = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.add_a   = acc_q;
    assign bus.product = product_q;
    assign bus.done    = done_q;
    assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_mult_shift_add_seq.sv
// Directed bench for the shift-add multiplier controller.
// The shared adder is modelled here as a plain combinational sum.
module tb_mult_shift_add_seq;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mult_shift_add_seq_if #(.N(8)) bus ();

    mult_shift_add_seq #(.N(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.add_sum = bus.add_a + bus.add_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One operation: start pulse, 8 RUN cycles, done cycle, idle cycle.
    // With inject set, new operands and start are presented mid-RUN and
    // during the done cycle; both must be ignored.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp, input bit inject);
        logic [15:0] eb;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dataa_in = a;
        bus.datab_in = b;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            eb = b[i] ? (16'(a) << i) : 16'h0;
            chk($sformatf("run_busy[%0d]", i), 32'(bus.busy), 32'd1);
            chk($sformatf("run_done[%0d]", i), 32'(bus.done), 32'd0);
            chk($sformatf("add_b[%0d]", i), 32'(bus.add_b), 32'(eb));
            if (inject && i == 3) begin
                bus.start    = 1'b1;
                bus.dataa_in = ~a;
                bus.datab_in = ~b;
            end else if (inject && i == 4) begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("done_busy", 32'(bus.busy), 32'd1);
        chk("product", 32'(bus.product), 32'(exp));
        chk("done_add_b", 32'(bus.add_b), 32'd0);
        if (inject) begin
            bus.start    = 1'b1;
            bus.dataa_in = 8'd3;
            bus.datab_in = 8'd3;
        end
        @(negedge clk);
        bus.start = 1'b0;
        chk("after_done", 32'(bus.done), 32'd0);
        chk("after_busy", 32'(bus.busy), 32'd0);
        chk("held_product", 32'(bus.product), 32'(exp));
    endtask

    initial begin
        int n;
        int lowc;
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.dataa_in = 8'd0;
        bus.datab_in = 8'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_product", 32'(bus.product), 32'd0);
        chk("rst_add_a", 32'(bus.add_a), 32'd0);
        chk("rst_add_b", 32'(bus.add_b), 32'd0);
        reset = 1'b0;

        run_op(8'd15, 8'd104, 16'h0618, 1'b0);
        run_op(8'd255, 8'd255, 16'hFE01, 1'b0);
        run_op(8'd0, 8'd15, 16'h0000, 1'b0);
        run_op(8'd60, 8'd0, 16'h0000, 1'b0);
        run_op(8'd10, 8'd20, 16'd200, 1'b1);
        run_op(8'd60, 8'd72, 16'h10E0, 1'b0);

        // Abort at RUN cycle 4 of 3*5
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dataa_in = 8'd3;
        bus.datab_in = 8'd5;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_abort_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_product", 32'(bus.product), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_add_a", 32'(bus.add_a), 32'd0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done) n++;
        end
        chk("abort_no_done", 32'(n), 32'd0);
        run_op(8'd3, 8'd5, 16'd15, 1'b0);

        // Start held high: back-to-back 7*9
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dataa_in = 8'd7;
        bus.datab_in = 8'd9;
        n = 0;
        while (!bus.done && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("held_first_latency", 32'(n), 32'd9);
        chk("held_first_product", 32'(bus.product), 32'd63);
        for (int k = 0; k < 2; k++) begin
            n    = 0;
            lowc = 0;
            do begin
                @(negedge clk);
                n++;
                if (!bus.busy) lowc++;
            end while (!bus.done && n < 30);
            chk($sformatf("held_period[%0d]", k), 32'(n), 32'd10);
            chk($sformatf("held_idle[%0d]", k), 32'(lowc), 32'd1);
            chk($sformatf("held_product[%0d]", k), 32'(bus.product), 32'd63);
        end
        bus.start = 1'b0;
        repeat (12) @(negedge clk);
        chk("final_busy", 32'(bus.busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
